// File: rtl/butterfly_engine.sv
// Radix-2 complex butterfly: y = a + b*w', z = a - b*w', with the four real products
// computed one at a time on a shared external multiplier via a req/ack handshake.
module butterfly_engine #(
  parameter int DW   = 8,
  parameter int FRAC = 6,
  parameter int SAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            inv,
  input  logic            scale_en,
  input  logic [DW-1:0]   a_re,
  input  logic [DW-1:0]   a_im,
  input  logic [DW-1:0]   b_re,
  input  logic [DW-1:0]   b_im,
  input  logic [DW-1:0]   w_re,
  input  logic [DW-1:0]   w_im,
  output logic            mul_req,
  output logic [DW-1:0]   mul_a,
  output logic [DW-1:0]   mul_b,
  input  logic            mul_ack,
  input  logic [2*DW-1:0] mul_p,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   y_re,
  output logic [DW-1:0]   y_im,
  output logic [DW-1:0]   z_re,
  output logic [DW-1:0]   z_im,
  output logic            ovf
);

  // Working width: holds the full product plus rounding and every add with headroom.
  localparam int WW = 2 * DW + 2;
  localparam int unsigned RndSh = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [WW-1:0] Rnd = (FRAC > 0) ? (WW'(1) << RndSh) : '0;
  localparam logic [DW-1:0] MinV = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MaxV = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {StIdle, StMul, StSum, StOut, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      k_q;
  logic            scale_q;
  logic [DW-1:0]   a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
  logic [DW-1:0]   p_q [4];
  logic [DW:0]     t_re_q, t_im_q;
  logic [DW-1:0]   y_re_q, y_im_q, z_re_q, z_im_q;
  logic            ovf_q;

  logic [DW-1:0]   w_im_lat;
  logic [WW-1:0]   prod_ext;
  logic signed [WW-1:0] prod_sum;
  logic [DW:0]     prod_n;
  logic [WW-1:0]   s_y_re, s_y_im, s_z_re, s_z_im;
  logic [DW:0]     n_y_re, n_y_im, n_z_re, n_z_im;

  function automatic logic [WW-1:0] sext_dw(input logic [DW-1:0] v);
    return {{(WW-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [WW-1:0] sext_t(input logic [DW:0] v);
    return {{(WW-DW-1){v[DW]}}, v};
  endfunction

  // Returns {overflowed, narrowed value}; saturates or wraps depending on SAT.
  function automatic logic [DW:0] narrow(input logic [WW-1:0] v);
    logic          fits;
    logic [DW-1:0] r;
    fits = (&v[WW-1:DW-1]) | ~(|v[WW-1:DW-1]);
    r    = v[DW-1:0];
    if (!fits && SAT != 0) begin
      r = v[WW-1] ? MinV : MaxV;
    end
    return {~fits, r};
  endfunction

  // Rounded halving: (v + 1) >>> 1.
  function automatic logic [WW-1:0] halve(input logic [WW-1:0] v, input logic en);
    logic signed [WW-1:0] s;
    s = $signed(v + WW'(1));
    return en ? WW'(s >>> 1) : v;
  endfunction

  // Conjugation negates w_im; the most negative value saturates instead of wrapping.
  always_comb begin
    w_im_lat = w_im;
    if (inv) begin
      w_im_lat = (w_im == MinV) ? MaxV : DW'(-w_im);
    end
  end

  always_comb begin
    prod_ext = {{2{mul_p[2*DW-1]}}, mul_p};
    prod_sum = $signed(prod_ext + Rnd);
    prod_n   = narrow(WW'(prod_sum >>> FRAC));
  end

  always_comb begin
    s_y_re = halve(sext_dw(a_re_q) + sext_t(t_re_q), scale_q);
    s_y_im = halve(sext_dw(a_im_q) + sext_t(t_im_q), scale_q);
    s_z_re = halve(sext_dw(a_re_q) - sext_t(t_re_q), scale_q);
    s_z_im = halve(sext_dw(a_im_q) - sext_t(t_im_q), scale_q);
    n_y_re = narrow(s_y_re);
    n_y_im = narrow(s_y_im);
    n_z_re = narrow(s_z_re);
    n_z_im = narrow(s_z_im);
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_q == StMul) begin
      unique case (k_q)
        2'd0: begin mul_a = w_re_q; mul_b = b_re_q; end
        2'd1: begin mul_a = w_im_q; mul_b = b_im_q; end
        2'd2: begin mul_a = w_im_q; mul_b = b_re_q; end
        2'd3: begin mul_a = w_re_q; mul_b = b_im_q; end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StMul;
      StMul:  if (mul_ack && k_q == 2'd3) state_d = StSum;
      StSum:  state_d = StOut;
      StOut:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      scale_q <= 1'b0;
      a_re_q  <= '0;
      a_im_q  <= '0;
      b_re_q  <= '0;
      b_im_q  <= '0;
      w_re_q  <= '0;
      w_im_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        p_q[i] <= '0;
      end
      t_re_q  <= '0;
      t_im_q  <= '0;
      y_re_q  <= '0;
      y_im_q  <= '0;
      z_re_q  <= '0;
      z_im_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        a_re_q  <= a_re;
        a_im_q  <= a_im;
        b_re_q  <= b_re;
        b_im_q  <= b_im;
        w_re_q  <= w_re;
        w_im_q  <= w_im_lat;
        scale_q <= scale_en;
        k_q     <= '0;
        ovf_q   <= 1'b0;
      end
      // Abort freezes all datapath state, so outputs and ovf keep their last values.
      if (!abort) begin
        case (state_q)
          StMul: begin
            if (mul_ack) begin
              p_q[k_q] <= prod_n[DW-1:0];
              ovf_q    <= ovf_q | prod_n[DW];
              k_q      <= k_q + 2'd1;
            end
          end
          StSum: begin
            t_re_q <= {p_q[0][DW-1], p_q[0]} - {p_q[1][DW-1], p_q[1]};
            t_im_q <= {p_q[2][DW-1], p_q[2]} + {p_q[3][DW-1], p_q[3]};
          end
          StOut: begin
            y_re_q <= n_y_re[DW-1:0];
            y_im_q <= n_y_im[DW-1:0];
            z_re_q <= n_z_re[DW-1:0];
            z_im_q <= n_z_im[DW-1:0];
            ovf_q  <= ovf_q | n_y_re[DW] | n_y_im[DW] | n_z_re[DW] | n_z_im[DW];
          end
          default: ;
        endcase
      end
    end
  end

  assign mul_req = (state_q == StMul);
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign y_re    = y_re_q;
  assign y_im    = y_im_q;
  assign z_re    = z_re_q;
  assign z_im    = z_im_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_butterfly_engine.sv
// Self-checking bench for butterfly_engine: directed vectors, stalls, abort/reset
// scenarios and randomized operations against an integer reference model.
module tb_butterfly_engine;

  localparam int DW   = 8;
  localparam int FRAC = 6;
  localparam int MAXV = 127;
  localparam int MINV = -128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, inv = 1'b0, scale_en = 1'b0;
  logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
  logic mul_req;
  logic signed [DW-1:0] mul_a, mul_b;
  logic mul_ack = 1'b1;
  logic signed [2*DW-1:0] mul_p;
  logic busy, done, ovf;
  logic signed [DW-1:0] y_re, y_im, z_re, z_im;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit iv, sc;
    int yr, yi, zr, zi;
    bit ov;
  } vec_t;

  butterfly_engine #(.DW(DW), .FRAC(FRAC), .SAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .inv(inv), .scale_en(scale_en),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p),
    .busy(busy), .done(done), .y_re(y_re), .y_im(y_im), .z_re(z_re), .z_im(z_im),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Ideal external multiplier.
  assign mul_p = (2*DW)'(mul_a) * (2*DW)'(mul_b);

  function automatic bit out_of_range(input int v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic int clip(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int rnd(input int x);
    return (x + (1 << (FRAC - 1))) >>> FRAC;
  endfunction

  // Reference: complex butterfly in plain integer arithmetic.
  task automatic model(inout vec_t v);
    int wim, q;
    int p[4];
    int s[4];
    bit o;
    o   = 1'b0;
    wim = v.iv ? ((v.wi == MINV) ? MAXV : -v.wi) : v.wi;
    q = rnd(v.wr * v.br); o |= out_of_range(q); p[0] = clip(q);
    q = rnd(wim * v.bi);  o |= out_of_range(q); p[1] = clip(q);
    q = rnd(wim * v.br);  o |= out_of_range(q); p[2] = clip(q);
    q = rnd(v.wr * v.bi); o |= out_of_range(q); p[3] = clip(q);
    s[0] = v.ar + (p[0] - p[1]);
    s[1] = v.ai + (p[2] + p[3]);
    s[2] = v.ar - (p[0] - p[1]);
    s[3] = v.ai - (p[2] + p[3]);
    for (int i = 0; i < 4; i++) begin
      if (v.sc) s[i] = (s[i] + 1) >>> 1;
      o |= out_of_range(s[i]);
      s[i] = clip(s[i]);
    end
    v.yr = s[0]; v.yi = s[1]; v.zr = s[2]; v.zi = s[3]; v.ov = o;
  endtask

  task automatic drive_ops(input vec_t v);
    a_re = DW'(v.ar); a_im = DW'(v.ai);
    b_re = DW'(v.br); b_im = DW'(v.bi);
    w_re = DW'(v.wr); w_im = DW'(v.wi);
    inv = v.iv; scale_en = v.sc;
  endtask

  // Runs one operation. Stalls st_n cycles on product st_k, re-pulses start in cycle xs.
  // Returns the done cycle (0 on timeout), products accepted and operand-order errors.
  task automatic do_op(input vec_t v, input int st_k, input int st_n, input int xs,
                       output int lat, output int acc, output int bad);
    int wimp, cyc, st_left;
    int ea[4];
    int eb[4];
    wimp = v.iv ? ((v.wi == MINV) ? MAXV : -v.wi) : v.wi;
    ea = '{v.wr, wimp, wimp, v.wr};
    eb = '{v.br, v.bi, v.br, v.bi};
    @(negedge clk);
    drive_ops(v);
    start = 1'b1;
    mul_ack = 1'b1;
    @(posedge clk);
    lat = 0; acc = 0; bad = 0; cyc = 0; st_left = st_n;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == xs);
      if (done) begin
        lat = cyc;
        break;
      end
      if (mul_req) begin
        if (acc >= 4) bad++;
        else if (mul_a !== DW'(ea[acc]) || mul_b !== DW'(eb[acc])) bad++;
        if (acc == st_k && st_left > 0) begin
          mul_ack = 1'b0;
          st_left--;
        end else begin
          mul_ack = 1'b1;
        end
        if (mul_ack) acc++;
      end else begin
        mul_ack = 1'b1;
      end
    end
    start = 1'b0;
    mul_ack = 1'b1;
  endtask

  function automatic vec_t mk(input int ar, ai, br, bi, wr, wi, input bit iv, sc,
                              input int yr, yi, zr, zi, input bit ov);
    vec_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi;
    v.iv = iv; v.sc = sc; v.yr = yr; v.yi = yi; v.zr = zr; v.zi = zi; v.ov = ov;
    return v;
  endfunction

  vec_t vecs[6];

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({busy, done, mul_req, mul_a, mul_b, y_re, y_im, z_re, z_im, ovf} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: busy=%b done=%b req=%b a=%0d b=%0d y=(%0d,%0d) z=(%0d,%0d) ovf=%b, required all 0",
               busy, done, mul_req, mul_a, mul_b, y_re, y_im, z_re, z_im, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    int lat, acc, bad;
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i], 0, 0, 0, lat, acc, bad);
      n_checks++;
      if (lat !== 7) begin
        n_errors++;
        $display("FAIL vec%0d latency: got %0d required 7", i, lat);
      end
      n_checks++;
      if (acc !== 4 || bad !== 0) begin
        n_errors++;
        $display("FAIL vec%0d products: accepted %0d bad operands %0d, required 4 and 0",
                 i, acc, bad);
      end
      n_checks++;
      if ({y_re, y_im, z_re, z_im} !==
          {DW'(vecs[i].yr), DW'(vecs[i].yi), DW'(vecs[i].zr), DW'(vecs[i].zi)}) begin
        n_errors++;
        $display("FAIL vec%0d result: got y=(%0d,%0d) z=(%0d,%0d) required y=(%0d,%0d) z=(%0d,%0d)",
                 i, y_re, y_im, z_re, z_im, vecs[i].yr, vecs[i].yi, vecs[i].zr, vecs[i].zi);
      end
      n_checks++;
      if (ovf !== vecs[i].ov) begin
        n_errors++;
        $display("FAIL vec%0d ovf: got %b required %b", i, ovf, vecs[i].ov);
      end
    end
  endtask

  task automatic test_stall();
    int lat, acc, bad;
    do_op(vecs[0], 1, 3, 0, lat, acc, bad);
    n_checks++;
    if (lat !== 10) begin
      n_errors++;
      $display("FAIL stall latency: got %0d required 10", lat);
    end
    n_checks++;
    if (acc !== 4 || bad !== 0) begin
      n_errors++;
      $display("FAIL stall operands: accepted %0d unstable/wrong %0d, required 4 and 0", acc, bad);
    end
    n_checks++;
    if ({y_re, y_im, z_re, z_im} !== {8'sd30, 8'sd2, -8'sd10, 8'sd8}) begin
      n_errors++;
      $display("FAIL stall result: got y=(%0d,%0d) z=(%0d,%0d) required y=(30,2) z=(-10,8)",
               y_re, y_im, z_re, z_im);
    end
  endtask

  task automatic test_random();
    int lat, acc, bad, st_k, st_n;
    vec_t v;
    for (int i = 0; i < 40; i++) begin
      v.ar = int'($urandom_range(255)) - 128; v.ai = int'($urandom_range(255)) - 128;
      v.br = int'($urandom_range(255)) - 128; v.bi = int'($urandom_range(255)) - 128;
      v.wr = int'($urandom_range(255)) - 128; v.wi = int'($urandom_range(255)) - 128;
      v.iv = 1'($urandom_range(1)); v.sc = 1'($urandom_range(1));
      model(v);
      st_k = int'($urandom_range(3));
      st_n = int'($urandom_range(2));
      do_op(v, st_k, st_n, 0, lat, acc, bad);
      n_checks++;
      if (lat !== 7 + st_n || bad !== 0) begin
        n_errors++;
        $display("FAIL rand%0d timing: latency %0d bad operands %0d, required %0d and 0",
                 i, lat, bad, 7 + st_n);
      end
      n_checks++;
      if ({y_re, y_im, z_re, z_im, ovf} !== {DW'(v.yr), DW'(v.yi), DW'(v.zr), DW'(v.zi), v.ov}) begin
        n_errors++;
        $display("FAIL rand%0d result: got y=(%0d,%0d) z=(%0d,%0d) ovf=%b required y=(%0d,%0d) z=(%0d,%0d) ovf=%b",
                 i, y_re, y_im, z_re, z_im, ovf, v.yr, v.yi, v.zr, v.zi, v.ov);
      end
    end
  endtask

  task automatic test_start_in_mul();
    int lat, acc, bad;
    do_op(vecs[1], 0, 0, 2, lat, acc, bad);
    n_checks++;
    if (lat !== 7 || acc !== 4 || bad !== 0) begin
      n_errors++;
      $display("FAIL start_in_mul: latency %0d accepted %0d bad %0d, required 7 4 0",
               lat, acc, bad);
    end
    n_checks++;
    if ({y_re, y_im, z_re, z_im} !== {8'sd7, -8'sd15, 8'sd13, 8'sd25}) begin
      n_errors++;
      $display("FAIL start_in_mul result: got y=(%0d,%0d) z=(%0d,%0d) required y=(7,-15) z=(13,25)",
               y_re, y_im, z_re, z_im);
    end
  endtask

  task automatic test_abort();
    int lat, acc, bad, seen;
    do_op(vecs[0], 0, 0, 0, lat, acc, bad);
    @(negedge clk);
    drive_ops(vecs[3]);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (!(busy === 1'b1 && mul_req === 1'b0 && done === 1'b0)) begin
      n_errors++;
      $display("FAIL abort_setup: busy=%b req=%b done=%b, required SUM (1,0,0)",
               busy, mul_req, done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if ({y_re, y_im, z_re, z_im, ovf} !== {8'sd30, 8'sd2, -8'sd10, 8'sd8, 1'b0}) begin
      n_errors++;
      $display("FAIL abort_hold: got y=(%0d,%0d) z=(%0d,%0d) ovf=%b required y=(30,2) z=(-10,8) ovf=0",
               y_re, y_im, z_re, z_im, ovf);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL abort_no_done: got %0d done cycles required 0", seen);
    end
  endtask

  task automatic test_rst_mid();
    int lat, acc, bad;
    do_op(vecs[0], 0, 0, 0, lat, acc, bad);
    @(negedge clk);
    drive_ops(vecs[1]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, mul_req, mul_a, mul_b, y_re, y_im, z_re, z_im, ovf} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid: busy=%b done=%b req=%b a=%0d b=%0d y=(%0d,%0d) z=(%0d,%0d) ovf=%b, required all 0",
               busy, done, mul_req, mul_a, mul_b, y_re, y_im, z_re, z_im, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(vecs[1], 0, 0, 0, lat, acc, bad);
    n_checks++;
    if (lat !== 7 || {y_re, y_im, z_re, z_im} !== {8'sd7, -8'sd15, 8'sd13, 8'sd25}) begin
      n_errors++;
      $display("FAIL rst_fresh: latency %0d y=(%0d,%0d) z=(%0d,%0d) required 7 y=(7,-15) z=(13,25)",
               lat, y_re, y_im, z_re, z_im);
    end
  endtask

  task automatic test_done_start_ignored();
    int lat, acc, bad;
    do_op(vecs[0], 0, 0, 0, lat, acc, bad);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mul_req !== 1'b0) begin
      n_errors++;
      $display("FAIL done_start: busy=%b req=%b required 0 0", busy, mul_req);
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc, bad;
    do_op(vecs[0], 0, 0, 0, lat, acc, bad);
    do_op(vecs[2], 0, 0, 0, lat, acc, bad);
    n_checks++;
    if (lat !== 7 || acc !== 4) begin
      n_errors++;
      $display("FAIL b2b timing: latency %0d accepted %0d required 7 4", lat, acc);
    end
    n_checks++;
    if ({y_re, y_im, z_re, z_im} !== {8'sd13, 8'sd25, 8'sd7, -8'sd15}) begin
      n_errors++;
      $display("FAIL b2b result: got y=(%0d,%0d) z=(%0d,%0d) required y=(13,25) z=(7,-15)",
               y_re, y_im, z_re, z_im);
    end
  endtask

  initial begin
    vecs[0] = mk(10, 5, 20, -3, 64, 0, 0, 0, 30, 2, -10, 8, 0);
    vecs[1] = mk(10, 5, 20, -3, 0, -64, 0, 0, 7, -15, 13, 25, 0);
    vecs[2] = mk(10, 5, 20, -3, 0, -64, 1, 0, 13, 25, 7, -15, 0);
    vecs[3] = mk(100, 0, 100, 0, 64, 0, 0, 0, 127, 0, 0, 0, 1);
    vecs[4] = mk(100, 0, 100, 0, 64, 0, 0, 1, 100, 0, 0, 0, 0);
    vecs[5] = mk(0, 0, 0, 64, 0, -128, 1, 0, -127, 0, 127, 0, 0);
    test_reset();
    test_vectors();
    test_stall();
    test_start_in_mul();
    test_abort();
    test_rst_mid();
    test_done_start_ignored();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
